seg14_scroll_driver: RTL and testbench
======================================

Name: seg14_scroll_driver

Overview:
Upstream message engine for the 12-digit 14-segment display. It holds a writable character buffer and decodes characters to 14-segment glyphs. It time-multiplexes the glyphs onto one-hot digit selects and scrolls messages longer than the display. Its sel/segm outputs go straight to the display pads, replacing hard-coded text with runtime-loadable text.

Parameters:
NUM_DIGITS, 12, number of display digits (width of sel)
MSG_DEPTH, 32, character buffer entries (power of two)
REFRESH_DIV, 1, clk cycles per digit slot (>=1)
SCROLL_DIV, 64, frames per scroll step (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
wr_en  input  1  buffer write strobe, accepted every cycle
wr_addr  input  log2(MSG_DEPTH)  buffer write address
wr_data  input  6  character code
msg_len  input  6  active message length in characters
scroll_en  input  1  enables scroll stepping
blink  input  1  blink request (only with SEG14_BLINK_EN)
frame_start  output  1  one-cycle pulse when digit 0 is driven
sel  output  NUM_DIGITS  one-hot digit select, bit d = digit d
segm  output  14  segment pattern for the selected digit

Behaviour:
- Reset (async, rst=1): sel=0, segm=0, frame_start=0. All counters and the scroll offset are 0. Every buffer entry is 0 (space). The first output update occurs on the first refresh tick after rst falls.
- Character codes: 0=space, 1..26=A..Z, 27..36=digits 0..9. Codes 37..63 decode to blank.
- Glyphs follow the team seg14 table, for example:
  - A=11101111000000, B=11110001010010, E=10011110000000, G=10111101000000
  - L=00011100000000, N=01101100100100, O=11111100000000, P=11001111000000, space=0.
- Refresh: a prescaler produces a tick every REFRESH_DIV cycles. The digit counter d steps 0..NUM_DIGITS-1 and then wraps to 0. One pass of d is one frame.
- Pipeline: address calc, then registered buffer read, then decode and output register. sel and segm update together and are always consistent.
  - Latency is 2 clk from the digit counter update to the matching sel/segm.
  - frame_start is aligned with the cycle sel becomes bit 0.
- Effective length: L = min(msg_len, MSG_DEPTH). msg_len and scroll_en are sampled only at the frame boundary, when d wraps to 0.
- Character index for digit d:
  - L > NUM_DIGITS: index = (offset+d) mod L.
  - L <= NUM_DIGITS: index = d for d<L, blank for d>=L; offset is held at 0.
  - L = 0: all digits blank, but sel keeps scanning.
- Scroll: a frame counter counts 0..SCROLL_DIV-1. On wrap, if scroll_en=1 and L>NUM_DIGITS, offset = (offset+1) mod L. The step takes effect at a frame boundary only, so there is no tearing mid-frame.
  - If a newly sampled L makes offset >= L, offset is set to 0.
  - scroll_en=0 freezes the offset; the frame counter keeps running.
- Writes: a write lands at the clk edge. A same-cycle read of the same address returns the old data (read-before-write). The new character is visible on the next scan of that digit. Writes never stall.
- Reset mid-frame: outputs go to 0 immediately; the buffer is cleared.

Optional Feature:
SEG14_BLINK_EN.
- Defined: a blink phase bit toggles every SCROLL_DIV frames. While blink=1 and the phase is 1, segm is forced to 0; sel keeps scanning and frame_start is unaffected. blink=0 gives normal output. Phase resets to 0.
- Undefined: the blink input is ignored, no phase logic is synthesised, and segm is never masked.

Test Plan:
1. Reset, REFRESH_DIV=1, no writes -> sel walks 0x001,0x002..0x800 and wraps; segm=0 throughout; frame_start pulses every 12 clk with sel=0x001.
2. Write "PABLO" (codes 16,1,2,12,15) to addr 0..4, msg_len=5, scroll_en=0 -> the first five digits show P=11001111000000, A=11101111000000, B=11110001010010, L=00011100000000, O=11111100000000; digits 5..11 show segm=0.
3. Write 14 chars with E (code 5) at addr 13, msg_len=14, SCROLL_DIV=1, scroll_en=1:
   - Frame 0: digit 0 shows addr 0.
   - After 1 frame: digit 0 shows addr 1.
   - After 13 frames, digit 0 shows addr 13 (E=10011110000000) and digit 1 shows addr 0 (wrap).
   - After 14 frames, offset returns to 0.
4. Write addr 3 with code 7 (G) while sel=0x008 is being driven -> the current frame shows the old glyph; the next frame shows 10111101000000.
5. Mid-frame, change msg_len from 20 to 13 with offset=15 -> the current frame is unchanged; at the next boundary offset=0 and digit 0 shows addr 0.
6. Assert rst while sel=0x040 -> sel=0 and segm=0 asynchronously; after release, the display is all blank (buffer cleared).
   - With SEG14_BLINK_EN, blink=1, SCROLL_DIV=1: segm alternates between the glyphs and 0 on successive frames.

Source files
------------

// File: rtl/seg14_scroll_driver.sv
// seg14_scroll_driver: runtime-loadable character buffer, 14-segment decode, one-hot digit scan and scroll.
// Optional blink masking of segm is compiled in with `define SEG14_BLINK_EN.
module seg14_scroll_driver #(
    parameter int NUM_DIGITS  = 12,
    parameter int MSG_DEPTH   = 32,
    parameter int REFRESH_DIV = 1,
    parameter int SCROLL_DIV  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
    input  logic [5:0]                   wr_data,
    input  logic [5:0]                   msg_len,
    input  logic                         scroll_en,
    input  logic                         blink,
    output logic                         frame_start,
    output logic [NUM_DIGITS-1:0]        sel,
    output logic [13:0]                  segm
);
    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = LW + 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    // Segment order, bit 13 down to 0: a b c d e f g1 g2 h i j k l m.
    function automatic logic [13:0] glyph(input logic [5:0] code);
        logic [13:0] g;
        case (code)
            6'd1:  g = 14'b11101111000000; // A
            6'd2:  g = 14'b11110001010010; // B
            6'd3:  g = 14'b10011100000000; // C
            6'd4:  g = 14'b11110000010010; // D
            6'd5:  g = 14'b10011110000000; // E
            6'd6:  g = 14'b10001110000000; // F
            6'd7:  g = 14'b10111101000000; // G
            6'd8:  g = 14'b01101111000000; // H
            6'd9:  g = 14'b10010000010010; // I
            6'd10: g = 14'b01111000000000; // J
            6'd11: g = 14'b00001110001100; // K
            6'd12: g = 14'b00011100000000; // L
            6'd13: g = 14'b01101100101000; // M
            6'd14: g = 14'b01101100100100; // N
            6'd15: g = 14'b11111100000000; // O
            6'd16: g = 14'b11001111000000; // P
            6'd17: g = 14'b11111100000100; // Q
            6'd18: g = 14'b11001111000100; // R
            6'd19: g = 14'b10110111000000; // S
            6'd20: g = 14'b10000000010010; // T
            6'd21: g = 14'b01111100000000; // U
            6'd22: g = 14'b00001100001001; // V
            6'd23: g = 14'b01101100000101; // W
            6'd24: g = 14'b00000000101101; // X
            6'd25: g = 14'b00000000101010; // Y
            6'd26: g = 14'b10010000001001; // Z
            6'd27: g = 14'b11111100001001; // 0
            6'd28: g = 14'b01100000001000; // 1
            6'd29: g = 14'b11011011000000; // 2
            6'd30: g = 14'b11110001000000; // 3
            6'd31: g = 14'b01100111000000; // 4
            6'd32: g = 14'b10110111000000; // 5
            6'd33: g = 14'b10111111000000; // 6
            6'd34: g = 14'b11100000000000; // 7
            6'd35: g = 14'b11111111000000; // 8
            6'd36: g = 14'b11110111000000; // 9
            default: g = '0;
        endcase
        return g;
    endfunction

    logic [PW-1:0] pre_q, pre_d;
    logic          tick, active_q, upd_q;
    logic [DW-1:0] d_q, d_d;
    logic [LW-1:0] len_q, len_d, len_new;
    logic [AW-1:0] off_q, off_d, off_base;
    logic [FW-1:0] fc_q, fc_d;
    logic          boundary, fc_wrap, last_digit;

    // The first tick after reset opens frame 0 without counting as a completed frame.
    always_comb begin
        tick       = (pre_q == PW'(REFRESH_DIV - 1));
        pre_d      = tick ? '0 : pre_q + PW'(1);
        last_digit = (d_q == DW'(NUM_DIGITS - 1));
        fc_wrap    = (fc_q == FW'(SCROLL_DIV - 1));
        boundary   = tick && (!active_q || last_digit);
        len_new    = (int'(msg_len) > MSG_DEPTH) ? LW'(MSG_DEPTH) : LW'(msg_len);
        d_d        = d_q;
        len_d      = len_q;
        off_d      = off_q;
        fc_d       = fc_q;
        off_base   = '0;
        if (tick && active_q && !last_digit) d_d = d_q + DW'(1);
        if (boundary) begin
            d_d   = '0;
            len_d = len_new;
            if (len_new > LW'(NUM_DIGITS)) begin
                off_base = ({1'b0, off_q} >= len_new) ? '0 : off_q;
                if (active_q && fc_wrap && scroll_en)
                    off_d = (({1'b0, off_base} + LW'(1)) == len_new) ? '0 : off_base + AW'(1);
                else
                    off_d = off_base;
            end else begin
                off_d = '0;
            end
            if (active_q) fc_d = fc_wrap ? '0 : fc_q + FW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q    <= '0;
            active_q <= 1'b0;
            upd_q    <= 1'b0;
            d_q      <= '0;
            len_q    <= '0;
            off_q    <= '0;
            fc_q     <= '0;
        end else begin
            pre_q    <= pre_d;
            active_q <= active_q | tick;
            upd_q    <= tick;
            d_q      <= d_d;
            len_q    <= len_d;
            off_q    <= off_d;
            fc_q     <= fc_d;
        end
    end

    logic [SW-1:0] sum;
    logic [AW-1:0] rd_addr;
    logic          rd_blank;

    // offset < L and d < NUM_DIGITS < L, so one conditional subtract is a full modulo.
    always_comb begin
        sum = SW'(off_q) + SW'(d_q);
        if (sum >= SW'(len_q)) sum = sum - SW'(len_q);
        if (len_q > LW'(NUM_DIGITS)) begin
            rd_addr  = AW'(sum);
            rd_blank = 1'b0;
        end else begin
            rd_addr  = AW'(d_q);
            rd_blank = (LW'(d_q) >= len_q);
        end
    end

    logic [5:0] mem_q [MSG_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MSG_DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    logic          p1_vld_q, p1_new_q, p1_blank_q;
    logic [DW-1:0] p1_d_q;
    logic [5:0]    p1_char_q;
    logic [NUM_DIGITS-1:0] sel_d;
    logic [13:0]   segm_d;
    logic          fs_d;

`ifdef SEG14_BLINK_EN
    logic phase_q, p1_ph_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b0;
            p1_ph_q <= 1'b0;
        end else begin
            if (boundary && active_q && fc_wrap) phase_q <= ~phase_q;
            p1_ph_q <= phase_q;
        end
    end
`else
    logic blink_unused;
    assign blink_unused = blink;
`endif

    // Stage 1 reads the buffer with the old word on a same-address write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_vld_q   <= 1'b0;
            p1_new_q   <= 1'b0;
            p1_blank_q <= 1'b0;
            p1_d_q     <= '0;
            p1_char_q  <= '0;
        end else begin
            p1_vld_q   <= active_q;
            p1_new_q   <= upd_q;
            p1_blank_q <= rd_blank;
            p1_d_q     <= d_q;
            p1_char_q  <= mem_q[rd_addr];
        end
    end

    always_comb begin
        sel_d  = p1_vld_q ? (NUM_DIGITS'(1) << p1_d_q) : '0;
        segm_d = (p1_vld_q && !p1_blank_q) ? glyph(p1_char_q) : '0;
        fs_d   = p1_vld_q && p1_new_q && (p1_d_q == '0);
`ifdef SEG14_BLINK_EN
        if (blink && p1_ph_q) segm_d = '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel         <= '0;
            segm        <= '0;
            frame_start <= 1'b0;
        end else begin
            sel         <= sel_d;
            segm        <= segm_d;
            frame_start <= fs_d;
        end
    end
endmodule

// File: tb/tb_seg14_scroll_driver.sv
// Directed bench for seg14_scroll_driver: scan, decode, scroll, live writes, length change and reset.
module tb_seg14_scroll_driver;
    logic        clk = 1'b0;
    logic        rst, wr_en, scroll_en, blink, frame_start;
    logic [4:0]  wr_addr;
    logic [5:0]  wr_data, msg_len;
    logic [11:0] sel;
    logic [13:0] segm;

    int checks = 0;
    int errors = 0;

    logic [5:0] buf_m [32];
    int off_m, len_m;

    int         hk_digit, hk_len;
    bit         hk_len_vld, hk_se_vld, hk_se, hk_wr_vld;
    logic [4:0] hk_addr;
    logic [5:0] hk_data;

    seg14_scroll_driver #(
        .NUM_DIGITS(12), .MSG_DEPTH(32), .REFRESH_DIV(1), .SCROLL_DIV(1)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .msg_len(msg_len), .scroll_en(scroll_en), .blink(blink),
        .frame_start(frame_start), .sel(sel), .segm(segm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] g_exp(input logic [5:0] c);
        case (c)
            6'd0:  return 14'b00000000000000;
            6'd1:  return 14'b11101111000000;
            6'd2:  return 14'b11110001010010;
            6'd5:  return 14'b10011110000000;
            6'd7:  return 14'b10111101000000;
            6'd12: return 14'b00011100000000;
            6'd14: return 14'b01101100100100;
            6'd15: return 14'b11111100000000;
            6'd16: return 14'b11001111000000;
            default: return 14'h3fff;
        endcase
    endfunction

    function automatic logic [13:0] exp_digit(input int d);
        if (len_m == 0) return 14'b0;
        if (len_m > 12) return g_exp(buf_m[(off_m + d) % len_m]);
        if (d < len_m) return g_exp(buf_m[d]);
        return 14'b0;
    endfunction

    task automatic apply_hook();
        if (hk_len_vld) msg_len = hk_len[5:0];
        if (hk_se_vld) scroll_en = hk_se;
        if (hk_wr_vld) begin
            wr_addr = hk_addr;
            wr_data = hk_data;
            wr_en   = 1'b1;
        end
    endtask

    task automatic clear_hook();
        hk_digit = -1; hk_len = 0;
        hk_len_vld = 0; hk_se_vld = 0; hk_se = 0; hk_wr_vld = 0;
        hk_addr = '0; hk_data = '0;
    endtask

    // Called on a negedge; captures one full frame and leaves us on the next frame's first negedge.
    task automatic capture_frame(input string tag, output int waited);
        int w = 0;
        while (frame_start !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        waited = w;
        chk({tag, " frame_start found"}, 32'(frame_start), 32'd1);
        for (int i = 0; i < 12; i++) begin
            if (i == hk_digit) apply_hook();
            chk($sformatf("%s sel d%0d", tag, i), 32'(sel), 32'(1) << i);
            chk($sformatf("%s segm d%0d", tag, i), 32'(segm), 32'(exp_digit(i)));
            chk($sformatf("%s fs d%0d", tag, i), 32'(frame_start), (i == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
            wr_en = 1'b0;
        end
        clear_hook();
    endtask

    task automatic wr(input int a, input int c);
        wr_addr = a[4:0];
        wr_data = c[5:0];
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en    = 1'b0;
        buf_m[a] = c[5:0];
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int w;
        int t3_codes [9] = '{14, 7, 0, 1, 15, 12, 2, 14, 5};
        int t5_codes [6] = '{1, 2, 5, 7, 12, 14};
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        msg_len = '0; scroll_en = 1'b0; blink = 1'b0;
        clear_hook();
        for (int i = 0; i < 32; i++) buf_m[i] = '0;
        off_m = 0; len_m = 0;

        // Reset state and first-frame latency
        repeat (3) @(negedge clk);
        chk("reset sel", 32'(sel), 32'd0);
        chk("reset segm", 32'(segm), 32'd0);
        chk("reset frame_start", 32'(frame_start), 32'd0);
        rst = 1'b0;
        w = 0;
        while (frame_start !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("first frame_start latency", 32'(w), 32'd3);

        // Empty buffer: blank scan with period 12
        capture_frame("t1 f0", w);
        capture_frame("t1 f1", w);
        chk("t1 frame period", 32'(w), 32'd0);

        // PABLO, blink input ignored in this build
        wr(0, 16); wr(1, 1); wr(2, 2); wr(3, 12); wr(4, 15);
        msg_len = 6'd5; len_m = 5; blink = 1'b1;
        settle();
        capture_frame("t2 pablo", w);
        blink = 1'b0;

        // 14 characters, E at 13, scroll one step per frame
        for (int i = 0; i < 9; i++) wr(5 + i, t3_codes[i]);
        msg_len = 6'd14; len_m = 14;
        settle();
        capture_frame("t3 off0", w);
        hk_digit = 5; hk_se_vld = 1; hk_se = 1;
        capture_frame("t3 off0 enable", w);
        for (int k = 1; k <= 13; k++) begin
            off_m = k;
            capture_frame($sformatf("t3 off%0d", k), w);
        end
        chk("t3 digit0 is E at off13", 32'(exp_digit(0)), 32'(14'b10011110000000));
        off_m = 0;
        hk_digit = 5; hk_se_vld = 1; hk_se = 0;
        capture_frame("t3 off wrap", w);
        capture_frame("t3 frozen", w);

        // Write addr 3 while digit 3 is on the pads
        hk_digit = 3; hk_wr_vld = 1; hk_addr = 5'd3; hk_data = 6'd7;
        capture_frame("t4 old glyph", w);
        buf_m[3] = 6'd7;
        capture_frame("t4 new glyph", w);

        // Grow to 20, scroll to 15, then shrink to 13 mid-frame
        for (int i = 0; i < 6; i++) wr(14 + i, t5_codes[i]);
        hk_digit = 5; hk_len_vld = 1; hk_len = 20; hk_se_vld = 1; hk_se = 1;
        capture_frame("t5 len20 request", w);
        len_m = 20;
        for (int k = 1; k <= 15; k++) begin
            off_m = k;
            if (k == 15) begin
                hk_digit = 5; hk_len_vld = 1; hk_len = 13; hk_se_vld = 1; hk_se = 0;
            end
            capture_frame($sformatf("t5 off%0d", k), w);
        end
        off_m = 0; len_m = 13;
        capture_frame("t5 len13 off0", w);

        // Asynchronous reset while digit 6 is driven
        w = 0;
        while (sel !== 12'h040 && w < 30) begin
            @(negedge clk);
            w++;
        end
        chk("t6 reached digit 6", 32'(sel), 32'h040);
        rst = 1'b1;
        #1;
        chk("t6 async sel", 32'(sel), 32'd0);
        chk("t6 async segm", 32'(segm), 32'd0);
        chk("t6 async frame_start", 32'(frame_start), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) buf_m[i] = '0;
        off_m = 0;
        capture_frame("t6 cleared", w);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
